// File: rtl/ssp_frame_rx.sv
// SSP link endpoint: oversampled framed 8-bit receive into a FIFO, plus a serial response shifter.
// Define SSP_RX_STATS_EN to add the word_cnt / err_cnt statistics outputs.
module ssp_frame_rx #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        ck_1356meg,
  input  logic        reset,
  input  logic        ssp_clk,
  input  logic        ssp_frame,
  input  logic        ssp_din,
  output logic        ssp_dout,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        ovf,
`ifdef SSP_RX_STATS_EN
  output logic        frm_err,
  output logic [15:0] word_cnt,
  output logic [7:0]  err_cnt
`else
  output logic        frm_err
`endif
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_t;

  // ---------------- input synchronisers and edge detection ----------------
  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] frm_sync;
  logic [SYNC_STAGES-1:0] din_sync;
  logic                   clk_dly;
  logic                   s_clk;
  logic                   s_frm;
  logic                   s_din;
  logic                   rise;
  logic                   fall;

  always_ff @(posedge ck_1356meg or posedge reset) begin
    if (reset) begin
      clk_sync <= '0;
      frm_sync <= '0;
      din_sync <= '0;
      clk_dly  <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ssp_clk};
      frm_sync <= {frm_sync[SYNC_STAGES-2:0], ssp_frame};
      din_sync <= {din_sync[SYNC_STAGES-2:0], ssp_din};
      clk_dly  <= clk_sync[SYNC_STAGES-1];
    end
  end

  always_comb begin
    s_clk = clk_sync[SYNC_STAGES-1];
    s_frm = frm_sync[SYNC_STAGES-1];
    s_din = din_sync[SYNC_STAGES-1];
    rise  = s_clk & ~clk_dly;
    fall  = ~s_clk & clk_dly;
  end

  // ---------------- receive framing FSM ----------------
  state_t      state;
  state_t      state_nxt;
  logic [2:0]  bit_cnt;
  logic [2:0]  bit_cnt_nxt;
  logic [7:0]  shreg;
  logic [7:0]  shreg_nxt;
  logic        push_pend;
  logic        push_pend_nxt;
  logic [7:0]  push_word;
  logic [7:0]  push_word_nxt;
  logic        frm_err_nxt;

  always_ff @(posedge ck_1356meg or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      push_pend <= 1'b0;
      push_word <= '0;
      frm_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shreg     <= shreg_nxt;
      push_pend <= push_pend_nxt;
      push_word <= push_word_nxt;
      frm_err   <= frm_err_nxt;
    end
  end

  // Bits enter at the LSB and move up, so the first (MSB) bit lands in bit 7 after eight shifts.
  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    shreg_nxt     = shreg;
    push_pend_nxt = 1'b0;
    push_word_nxt = push_word;
    frm_err_nxt   = 1'b0;
    if (rise) begin
      case (state)
        S_IDLE: begin
          if (s_frm) begin
            shreg_nxt   = {7'b0, s_din};
            bit_cnt_nxt = 3'd1;
            state_nxt   = S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (s_frm) begin
            frm_err_nxt = 1'b1;
            shreg_nxt   = {7'b0, s_din};
            bit_cnt_nxt = 3'd1;
          end else begin
            shreg_nxt = {shreg[6:0], s_din};
            if (bit_cnt == 3'd7) begin
              push_pend_nxt = 1'b1;
              push_word_nxt = {shreg[6:0], s_din};
              bit_cnt_nxt   = '0;
              state_nxt     = S_IDLE;
            end else begin
              bit_cnt_nxt = bit_cnt + 3'd1;
            end
          end
        end
        default: begin
          state_nxt   = S_IDLE;
          bit_cnt_nxt = '0;
        end
      endcase
    end
  end

  // ---------------- receive FIFO ----------------
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_nxt;
  logic [PTR_W:0]   count;
  logic [PTR_W:0]   count_nxt;
  logic [PTR_W:0]   count_after_pop;
  logic [7:0]       rx_data_nxt;
  logic             do_pop;
  logic             do_push;
  logic             drop;

  // Pop is evaluated before push so a full FIFO still accepts a word in a pop cycle.
  always_comb begin
    do_pop          = (count != '0) & rx_ready;
    do_push         = push_pend & ((count != FULL_CNT) | do_pop);
    drop            = push_pend & (count == FULL_CNT) & ~do_pop;
    rd_ptr_nxt      = do_pop ? rd_ptr + PTR_W'(1) : rd_ptr;
    count_after_pop = count - {{PTR_W{1'b0}}, do_pop};
    count_nxt       = count_after_pop + {{PTR_W{1'b0}}, do_push};
    rx_data_nxt     = rx_data;
    if (count_after_pop != '0) begin
      rx_data_nxt = mem[rd_ptr_nxt];
    end else if (do_push) begin
      rx_data_nxt = push_word;
    end
  end

  always_ff @(posedge ck_1356meg) begin
    if (do_push) begin
      mem[wr_ptr] <= push_word;
    end
  end

  always_ff @(posedge ck_1356meg or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rx_data <= '0;
      ovf     <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      rd_ptr  <= rd_ptr_nxt;
      count   <= count_nxt;
      rx_data <= rx_data_nxt;
      if (drop) begin
        ovf <= 1'b1;
      end
    end
  end

  assign rx_valid = (count != '0);

  // ---------------- response shifter ----------------
  logic [7:0] tx_shreg;
  logic [2:0] tx_idx;

  always_ff @(posedge ck_1356meg or posedge reset) begin
    if (reset) begin
      tx_shreg <= '0;
      tx_idx   <= '0;
      tx_ready <= 1'b1;
      ssp_dout <= 1'b0;
    end else if (tx_valid && tx_ready) begin
      tx_shreg <= tx_data;
      tx_idx   <= '0;
      tx_ready <= 1'b0;
    end else if (fall && !tx_ready) begin
      ssp_dout <= tx_shreg[7];
      tx_shreg <= {tx_shreg[6:0], 1'b0};
      tx_idx   <= tx_idx + 3'd1;
      if (tx_idx == 3'd7) begin
        tx_ready <= 1'b1;
      end
    end
  end

`ifdef SSP_RX_STATS_EN
  // ---------------- statistics ----------------
  always_ff @(posedge ck_1356meg or posedge reset) begin
    if (reset) begin
      word_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      if (push_pend) begin
        word_cnt <= word_cnt + 16'd1;
      end
      if (frm_err && (err_cnt != '1)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ssp_frame_rx.sv
// Bench for ssp_frame_rx: pin-event timing model with per-cycle compare plus directed literal checks.
`timescale 1ns/1ps
module tb_ssp_frame_rx;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned SS    = 2;

  logic        ck_1356meg = 1'b0;
  logic        reset      = 1'b1;
  logic        ssp_clk    = 1'b0;
  logic        ssp_frame  = 1'b0;
  logic        ssp_din    = 1'b0;
  logic        rx_ready   = 1'b0;
  logic [7:0]  tx_data    = '0;
  logic        tx_valid   = 1'b0;
  logic        ssp_dout;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        tx_ready;
  logic        ovf;
  logic        frm_err;
`ifdef SSP_RX_STATS_EN
  logic [15:0] word_cnt;
  logic [7:0]  err_cnt;
`endif

  ssp_frame_rx #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(SS)) dut (
    .ck_1356meg(ck_1356meg),
    .reset(reset),
    .ssp_clk(ssp_clk),
    .ssp_frame(ssp_frame),
    .ssp_din(ssp_din),
    .ssp_dout(ssp_dout),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .ovf(ovf),
`ifdef SSP_RX_STATS_EN
    .frm_err(frm_err),
    .word_cnt(word_cnt),
    .err_cnt(err_cnt)
`else
    .frm_err(frm_err)
`endif
  );

  always #5 ck_1356meg = ~ck_1356meg;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // model state
  logic [7:0] mq[$];
  logic       m_ovf = 1'b0, m_err = 1'b0, m_txr = 1'b1, m_dout = 1'b0, p_clk = 1'b0;
  logic [7:0] m_word = '0, m_tx_word = '0;
  int         m_cnt = 0, m_tx_left = 0;
  logic [1:0] rise_ev[int];
  logic       fall_ev[int];
  logic [7:0] push_ev[int];

  // observation logs used by directed checks
  logic       prev_valid = 1'b0;
  logic [7:0] prev_data  = '0;
  logic [7:0] got_q[$];
  int         first_valid = -1, valid_n = 0, err_n = 0, last_rise = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: a pin edge seen at clock n takes effect at clock n+SS; a finished word is in the FIFO one clock later.
  initial begin : compare
    logic [1:0] ev;
    forever begin
      @(posedge ck_1356meg);
      cyc++;
      if (reset) begin
        mq.delete(); rise_ev.delete(); fall_ev.delete(); push_ev.delete();
        m_ovf = 1'b0; m_err = 1'b0; m_txr = 1'b1; m_dout = 1'b0; p_clk = 1'b0;
        m_cnt = 0; m_word = '0; m_tx_left = 0; m_tx_word = '0;
      end else begin
        if (prev_valid && rx_ready) got_q.push_back(prev_data);
        if (ssp_clk && !p_clk) rise_ev[cyc + int'(SS)] = {ssp_frame, ssp_din};
        if (!ssp_clk && p_clk) fall_ev[cyc + int'(SS)] = 1'b1;
        p_clk = ssp_clk;
        m_err = 1'b0;
        if (mq.size() > 0 && rx_ready) void'(mq.pop_front());
        if (push_ev.exists(cyc)) begin
          if (mq.size() < int'(DEPTH)) mq.push_back(push_ev[cyc]);
          else m_ovf = 1'b1;
          push_ev.delete(cyc);
        end
        if (rise_ev.exists(cyc)) begin
          ev = rise_ev[cyc];
          rise_ev.delete(cyc);
          if (ev[1]) begin
            if (m_cnt != 0) m_err = 1'b1;
            m_word = {7'b0, ev[0]};
            m_cnt  = 1;
          end else if (m_cnt != 0) begin
            m_word = {m_word[6:0], ev[0]};
            m_cnt++;
            if (m_cnt == 8) begin
              push_ev[cyc + 1] = m_word;
              m_cnt = 0;
            end
          end
        end
        if (tx_valid && m_txr) begin
          m_tx_word = tx_data; m_tx_left = 8; m_txr = 1'b0;
        end else if (fall_ev.exists(cyc) && !m_txr) begin
          m_dout    = m_tx_word[7];
          m_tx_word = {m_tx_word[6:0], 1'b0};
          m_tx_left--;
          if (m_tx_left == 0) m_txr = 1'b1;
        end
        if (fall_ev.exists(cyc)) fall_ev.delete(cyc);
      end
      #1;
      chk("rx_valid", int'(rx_valid), int'(mq.size() != 0));
      if (reset) chk("rx_data_rst", int'(rx_data), 0);
      else if (mq.size() != 0) chk("rx_data", int'(rx_data), int'(mq[0]));
      chk("ovf", int'(ovf), int'(m_ovf));
      chk("frm_err", int'(frm_err), int'(m_err));
      chk("tx_ready", int'(tx_ready), int'(m_txr));
      chk("ssp_dout", int'(ssp_dout), int'(m_dout));
      prev_valid = rx_valid;
      prev_data  = rx_data;
      if (rx_valid) begin
        valid_n++;
        if (first_valid < 0) first_valid = cyc;
      end
      if (frm_err) err_n++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge ck_1356meg);
  endtask

  // One SSP bit: 4 ck low, 4 ck high. pp pulses rx_ready for the clock the word would be pushed.
  task automatic send_bit(input logic f, input logic d, input logic pp);
    int c;
    ssp_frame = f; ssp_din = d;
    tick(4);
    ssp_clk = 1'b1; c = cyc; last_rise = c;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      if (pp) rx_ready = (cyc == c + int'(SS) + 1);
    end
    ssp_clk = 1'b0; ssp_frame = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic pp);
    for (int i = 7; i >= 0; i--) send_bit(i == 7, b[i], pp && (i == 0));
  endtask

  task automatic clear_logs();
    got_q.delete(); first_valid = -1; valid_n = 0; err_n = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_dout"}, int'(ssp_dout), 0);
    chk({tag, "_rx_data"}, int'(rx_data), 0);
    chk({tag, "_rx_valid"}, int'(rx_valid), 0);
    chk({tag, "_tx_ready"}, int'(tx_ready), 1);
    chk({tag, "_ovf"}, int'(ovf), 0);
    chk({tag, "_frm_err"}, int'(frm_err), 0);
  endtask

  initial begin : watchdog
    #400us;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int g;
    bit tx_bits [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tick(3);
    chk_reset_vals("init");
    reset = 1'b0;
    tick(4);

    // single word, consumer always ready
    rx_ready = 1'b1; clear_logs();
    send_byte(8'hA5, 1'b0);
    tick(12);
    chk("a5_latency", first_valid, last_rise + int'(SS) + 2);
    chk("a5_valid_cycles", valid_n, 1);
    g = (got_q.size() == 1) ? int'(got_q[0]) : -1;
    chk("a5_word", g, 'hA5);
    chk("a5_err", err_n, 0);

    // overflow: five words into a depth-4 FIFO, then drain
    rx_ready = 1'b0;
    for (int b = 1; b <= 5; b++) send_byte(8'(b), 1'b0);
    tick(12);
    chk("ovf_set", int'(ovf), 1);
    chk("ovf_valid", int'(rx_valid), 1);
    for (int b = 1; b <= 4; b++) begin
      chk("drain_word", int'(rx_data), b);
      rx_ready = 1'b1; tick(1); rx_ready = 1'b0;
    end
    chk("drain_empty", int'(rx_valid), 0);
    chk("ovf_sticky", int'(ovf), 1);

    reset = 1'b1; tick(3); reset = 1'b0; tick(4);

    // resync: 3 bits of 0xFF then a fresh frame carrying 0x3C
    rx_ready = 1'b1; clear_logs();
    for (int i = 0; i < 3; i++) send_bit(i == 0, 1'b1, 1'b0);
    send_byte(8'h3C, 1'b0);
    tick(12);
    chk("resync_err_pulses", err_n, 1);
    g = (got_q.size() == 1) ? int'(got_q[0]) : -1;
    chk("resync_word", g, 'h3C);

    // response shifter
    chk("tx_idle", int'(tx_ready), 1);
    tx_data = 8'hC3; tx_valid = 1'b1; tick(1); tx_valid = 1'b0;
    chk("tx_busy", int'(tx_ready), 0);
    for (int i = 0; i < 8; i++) begin
      ssp_clk = 1'b1; tick(4);
      ssp_clk = 1'b0; tick(4);
      chk("tx_bit", int'(ssp_dout), int'(tx_bits[i]));
      chk("tx_ready_after_fall", int'(tx_ready), (i == 7) ? 1 : 0);
    end

    // reset in the middle of an rx word and a tx word
    clear_logs();
    tx_data = 8'hFF; tx_valid = 1'b1; tick(1); tx_valid = 1'b0;
    for (int i = 0; i < 4; i++) send_bit(i == 0, 1'b1, 1'b0);
    reset = 1'b1; tick(3);
    chk_reset_vals("midword");
    reset = 1'b0; tick(4);
    clear_logs();
    send_byte(8'h7E, 1'b0);
    tick(12);
    g = (got_q.size() == 1) ? int'(got_q[0]) : -1;
    chk("after_reset_word", g, 'h7E);
    chk("after_reset_err", err_n, 0);

    // full FIFO with push and pop on the same clock
    rx_ready = 1'b0; clear_logs();
    for (int b = 0; b < 4; b++) send_byte(8'h11 + 8'(b), 1'b0);
    send_byte(8'h15, 1'b1);
    tick(6);
    chk("pushpop_no_ovf", int'(ovf), 0);
    rx_ready = 1'b1; tick(10); rx_ready = 1'b0;
    chk("pushpop_count", got_q.size(), 5);
    for (int i = 0; i < 5 && i < got_q.size(); i++) chk("pushpop_order", int'(got_q[i]), 'h11 + i);
`ifdef SSP_RX_STATS_EN
    chk("word_cnt", int'(word_cnt), 6);
    chk("err_cnt", int'(err_cnt), 0);
`endif

    tick(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
